// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences ALU, unified memory, IR and register file
// through fetch/decode/execute/memory/writeback states and counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRd,
  output logic             MemWr,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       REGdst,
  output logic             RegWrite,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCsrc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JAL     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic w_pcw, w_memrd, w_memwr, w_irw, w_regw;

  // Opcode dispatch out of DECODE.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:               decode_dispatch = S_MEMADR;
      OP_R:                       decode_dispatch = S_EXEC;
      OP_BEQ, OP_BNE:             decode_dispatch = S_BRANCH;
      OP_J:                       decode_dispatch = S_JUMP;
      OP_JAL:                     decode_dispatch = S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI:  decode_dispatch = S_IMMEX;
      default:                    decode_dispatch = S_ILLEGAL;
    endcase
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next = decode_dispatch(opcode);
      S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_IMMEX:   w_next = S_IMMWB;
      S_IMMWB:   w_next = S_FETCH;
      S_JAL:     w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ILLEGAL)
        r_illegal <= 1'b1;
      // An instruction retires when control returns to FETCH.
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_pcw    = 1'b0;
    w_memrd  = 1'b0;
    w_memwr  = 1'b0;
    w_irw    = 1'b0;
    w_regw   = 1'b0;
    IorD     = 1'b0;
    MemtoReg = 2'b00;
    REGdst   = 2'b00;
    ALUsrcA  = 1'b0;
    ALUsrcB  = 2'b00;
    ALUop    = 2'b00;
    PCsrc    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        ALUsrcB = 2'b01;
        w_irw   = mem_ready;
        w_pcw   = mem_ready;
      end
      S_DECODE: ALUsrcB = 2'b11;
      S_MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        w_memrd = 1'b1;
      end
      S_MEMWB: begin
        w_regw   = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEMWR: begin
        IorD    = 1'b1;
        w_memwr = 1'b1;
      end
      S_EXEC: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        REGdst = 2'b01;
      end
      S_BRANCH: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b01;
        PCsrc   = 2'b01;
        w_pcw   = (opcode == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        PCsrc = 2'b10;
        w_pcw = 1'b1;
      end
      S_JAL: begin
        PCsrc    = 2'b10;
        w_pcw    = 1'b1;
        w_regw   = 1'b1;
        REGdst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_IMMEX: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        ALUop   = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      S_IMMWB: w_regw = 1'b1;
      default: ;
    endcase
  end

  // Enables are masked during reset so an abandoned access never writes.
  assign PCWrite  = w_pcw   & ~reset;
  assign MemRd    = w_memrd & ~reset;
  assign MemWr    = w_memwr & ~reset;
  assign IRWrite  = w_irw   & ~reset;
  assign RegWrite = w_regw  & ~reset;

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle vector table pushed through a scoreboard
// queue, covering each instruction class, handshake stalls, illegal opcode, mid-access reset and counter wrap.
module tb_mc_control_fsm;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000,
                         SLTI = 6'b001010, ANDI = 6'b001100, BAD = 6'b111111;

  logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;

  logic PCWrite, IorD, MemRd, MemWr, IRWrite, RegWrite, ALUsrcA, illegal;
  logic [1:0] MemtoReg, REGdst, ALUsrcB, ALUop, PCsrc;
  logic [3:0] state;
  logic [31:0] retired;

  logic nPCWrite, nIorD, nMemRd, nMemWr, nIRWrite, nRegWrite, nALUsrcA, nillegal;
  logic [1:0] nMemtoReg, nREGdst, nALUsrcB, nALUop, nPCsrc;
  logic [3:0] nstate;
  logic [1:0] nretired;

  always #5 clock = ~clock;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .REGdst(REGdst), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ALUop(ALUop), .PCsrc(PCsrc), .state(state), .illegal(illegal),
    .retired(retired));

  mc_control_fsm #(.CNT_W(2)) dut_n (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(nPCWrite), .IorD(nIorD), .MemRd(nMemRd), .MemWr(nMemWr), .IRWrite(nIRWrite),
    .MemtoReg(nMemtoReg), .REGdst(nREGdst), .RegWrite(nRegWrite), .ALUsrcA(nALUsrcA),
    .ALUsrcB(nALUsrcB), .ALUop(nALUop), .PCsrc(nPCsrc), .state(nstate), .illegal(nillegal),
    .retired(nretired));

  // en = {PCWrite,MemRd,MemWr,IRWrite,RegWrite}; mux = {ALUsrcA,ALUsrcB,ALUop,PCsrc,IorD,MemtoReg,REGdst}
  wire [4:0]  en_w   = {PCWrite, MemRd, MemWr, IRWrite, RegWrite};
  wire [4:0]  en_n   = {nPCWrite, nMemRd, nMemWr, nIRWrite, nRegWrite};
  wire [11:0] mux_w  = {ALUsrcA, ALUsrcB, ALUop, PCsrc, IorD, MemtoReg, REGdst};
  wire [11:0] mux_n  = {nALUsrcA, nALUsrcB, nALUop, nPCsrc, nIorD, nMemtoReg, nREGdst};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [4:0]  en;
    logic        il;
    int          ret;
    int          retn;
    logic        mchk;
    logic [11:0] mux;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
  endtask

  task automatic v(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                   input logic [3:0] st, input logic [4:0] en, input logic il,
                   input int ret, input int retn);
    vec_t t;
    t.rst = rst; t.op = op; t.z = z; t.mr = mr; t.st = st; t.en = en; t.il = il;
    t.ret = ret; t.retn = retn; t.mchk = 1'b0; t.mux = '0;
    vecs.push_back(t);
  endtask

  task automatic m(input logic a, input logic [1:0] b, input logic [1:0] aop, input logic [1:0] pc,
                   input logic iord, input logic [1:0] mtr, input logic [1:0] rd);
    vecs[vecs.size()-1].mchk = 1'b1;
    vecs[vecs.size()-1].mux  = {a, b, aop, pc, iord, mtr, rd};
  endtask

  task automatic fetch1(input logic [5:0] op, input int ret, input int retn);
    v(0, op, 0, 1, 0, 5'b11010, 0, ret, retn); m(0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    v(0, op, 0, 0, 1, 5'b00000, 0, ret, -1);   m(0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'b00);
  endtask

  initial begin
    // reset, then lw with two-cycle stalls in FETCH and MEMRD
    v(1, LW, 0, 0, 0, 5'b00000, 0, 0, 0);
    v(0, LW, 0, 0, 0, 5'b01000, 0, 0, 0); m(0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    v(0, LW, 0, 0, 0, 5'b01000, 0, 0, -1);
    v(0, LW, 0, 1, 0, 5'b11010, 0, 0, -1);
    v(0, LW, 0, 0, 1, 5'b00000, 0, 0, -1); m(0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    v(0, LW, 0, 0, 2, 5'b00000, 0, 0, -1); m(1, 2'b10, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    v(0, LW, 0, 0, 3, 5'b01000, 0, 0, -1); m(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00);
    v(0, LW, 0, 0, 3, 5'b01000, 0, 0, -1);
    v(0, LW, 0, 1, 3, 5'b01000, 0, 0, -1);
    v(0, LW, 0, 0, 4, 5'b00001, 0, 0, -1); m(0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00);
    // branches: beq/bne with zero = 1 and 0
    fetch1(BEQ, 1, -1); v(0, BEQ, 1, 0, 8, 5'b10000, 0, 1, -1); m(1, 2'b00, 2'b01, 2'b01, 0, 2'b00, 2'b00);
    fetch1(BNE, 2, -1); v(0, BNE, 1, 0, 8, 5'b00000, 0, 2, -1);
    fetch1(BEQ, 3, -1); v(0, BEQ, 0, 0, 8, 5'b00000, 0, 3, -1);
    fetch1(BNE, 4, -1); v(0, BNE, 0, 0, 8, 5'b10000, 0, 4, -1);
    // jumps
    fetch1(J, 5, -1);   v(0, J, 0, 0, 9, 5'b10000, 0, 5, -1);    m(0, 2'b00, 2'b00, 2'b10, 0, 2'b00, 2'b00);
    fetch1(JAL, 6, -1); v(0, JAL, 0, 0, 12, 5'b10001, 0, 6, -1); m(0, 2'b00, 2'b00, 2'b10, 0, 2'b10, 2'b10);
    // immediates
    fetch1(ADDI, 7, -1); v(0, ADDI, 0, 0, 10, 5'b00000, 0, 7, -1); m(1, 2'b10, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    v(0, ADDI, 0, 0, 11, 5'b00001, 0, 7, -1); m(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00);
    fetch1(ANDI, 8, -1); v(0, ANDI, 0, 0, 10, 5'b00000, 0, 8, -1); m(1, 2'b10, 2'b11, 2'b00, 0, 2'b00, 2'b00);
    v(0, ANDI, 0, 0, 11, 5'b00001, 0, 8, -1);
    fetch1(SLTI, 9, -1); v(0, SLTI, 0, 0, 10, 5'b00000, 0, 9, -1); m(1, 2'b10, 2'b11, 2'b00, 0, 2'b00, 2'b00);
    v(0, SLTI, 0, 0, 11, 5'b00001, 0, 9, -1);
    // sw with one stall, then sw abandoned by reset in MEMWR
    fetch1(SW, 10, -1); v(0, SW, 0, 0, 2, 5'b00000, 0, 10, -1);
    v(0, SW, 0, 0, 5, 5'b00100, 0, 10, -1); m(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00);
    v(0, SW, 0, 1, 5, 5'b00100, 0, 10, -1);
    fetch1(SW, 11, -1); v(0, SW, 0, 0, 2, 5'b00000, 0, 11, -1);
    v(0, SW, 0, 0, 5, 5'b00100, 0, 11, -1);
    v(1, SW, 0, 0, 5, 5'b00000, 0, 11, -1);
    v(0, R, 0, 0, 0, 5'b01000, 0, 0, 0);
    // five R-type instructions: narrow counter wraps
    for (int i = 0; i < 5; i++) begin
      fetch1(R, i, i % 4);
      v(0, R, 0, 1, 6, 5'b00000, 0, i, -1); m(1, 2'b00, 2'b10, 2'b00, 0, 2'b00, 2'b00);
      v(0, R, 0, 1, 7, 5'b00001, 0, i, -1); m(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01);
    end
    // illegal opcode: sticky for 20 cycles, cleared by reset
    fetch1(BAD, 5, 1);
    for (int i = 0; i < 20; i++) v(0, BAD, i[0], ~i[1], 13, 5'b00000, 1, 5, 1);
    v(1, BAD, 1, 1, 13, 5'b00000, 1, 5, 1);
    v(0, R, 0, 0, 0, 5'b01000, 0, 0, 0);
    v(0, R, 0, 1, 0, 5'b11010, 0, 0, 0);

    reset = 1'b1;
    repeat (2) @(posedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(posedge clock);
      #1;
      reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
      exp_q.push_back(vecs[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      chk("state", i, {28'd0, state}, {28'd0, e.st});
      chk("state_n", i, {28'd0, nstate}, {28'd0, e.st});
      chk("enables", i, {27'd0, en_w}, {27'd0, e.en});
      chk("enables_n", i, {27'd0, en_n}, {27'd0, e.en});
      chk("illegal", i, {31'd0, illegal}, {31'd0, e.il});
      chk("illegal_n", i, {31'd0, nillegal}, {31'd0, e.il});
      if (e.ret >= 0) chk("retired", i, retired, e.ret);
      if (e.retn >= 0) chk("retired_n", i, {30'd0, nretired}, e.retn);
      if (e.mchk) begin
        chk("mux", i, {20'd0, mux_w}, {20'd0, e.mux});
        chk("mux_n", i, {20'd0, mux_n}, {20'd0, e.mux});
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
